txs_burst_writer: RTL and testbench

//  Avalon-MM burst write master: initiator side of the PCIe core TXS slave (host-memory write path).

---
 rtl/txs_burst_writer.sv | 192 +++++++++++++++++++
 tb/tb_txs_burst_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/txs_burst_writer.sv
// Avalon-MM burst write master: buffers 128-bit beats and writes fixed-length bursts into a host ring.
// Optional TXS_WR_STATS_EN adds saturating beat/stall counters (stat_beats, stat_stalls).
module txs_burst_writer #(
    parameter int ADDR_W     = 22,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk125,
    input  logic              npor,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       buf_bursts,
    input  logic              in_valid,
    input  logic [127:0]      in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              txs_write,
    output logic [127:0]      txs_writedata,
    output logic [ADDR_W-1:0] txs_address,
    output logic [5:0]        txs_burstcount,
    input  logic              txs_waitrequest,
    output logic              irq,
    output logic [15:0]       frame_count
`ifdef TXS_WR_STATS_EN
    ,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_stalls
`endif
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int STRIDE_SH = $clog2(BURST_LEN * 16);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, lasts_q, lasts_d;
    logic              full_q, full_d;
    logic              en_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [5:0]        lastcnt_q, lastcnt_d, frames_add;
    logic [15:0]       idx_q, idx_d, bufb_q, bufb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              irq_q, irq_d;
    logic [15:0]       frame_q, frame_d;

    // Beat storage holds {last, data}; data only, so no reset.
    logic [128:0]      mem_q [FIFO_DEPTH];
    logic [128:0]      head;
    logic              push, pop, pop_last, accept, burst_end, start;

    assign head      = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign accept    = txs_write & ~txs_waitrequest;
    assign pop       = accept & (state_q == ST_BURST);
    assign pop_last  = pop & head[128];
    assign burst_end = accept & (beat_q == BEAT_W'(BURST_LEN - 1));
    assign start     = (state_q == ST_IDLE) & enable &
                       ((count_q >= CNT_W'(BURST_LEN)) | (lasts_q != '0));
    assign frames_add = lastcnt_q + {5'd0, pop_last};

    always_ff @(posedge clk125) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        lasts_d   = lasts_q;
        beat_d    = beat_q;
        lastcnt_d = lastcnt_q;
        idx_d     = idx_q;
        bufb_d    = bufb_q;
        addr_d    = addr_q;
        irq_d     = 1'b0;
        frame_d   = frame_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        unique case ({push & in_last, pop_last})
            2'b10:   lasts_d = lasts_q + CNT_W'(1);
            2'b01:   lasts_d = lasts_q - CNT_W'(1);
            default: lasts_d = lasts_q;
        endcase
        full_d = (count_d == CNT_W'(FIFO_DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BURST;
                    bufb_d  = (buf_bursts == 16'd0) ? 16'd1 : buf_bursts;
                    addr_d  = base_addr + ADDR_W'({idx_q, {STRIDE_SH{1'b0}}});
                end
            end
            ST_BURST: begin
                if (burst_end)     state_d = ST_IDLE;
                else if (pop_last) state_d = ST_PAD;
            end
            ST_PAD: begin
                if (burst_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) beat_d = beat_q + BEAT_W'(1);
        lastcnt_d = lastcnt_q + {5'd0, pop_last};
        // Burst close: advance the ring slot and credit every frame that ended inside it.
        if (burst_end) begin
            beat_d    = '0;
            lastcnt_d = '0;
            idx_d     = (idx_q >= bufb_q - 16'd1) ? 16'd0 : idx_q + 16'd1;
            irq_d     = (frames_add != 6'd0);
            frame_d   = frame_q + {10'd0, frames_add};
        end
    end

    always_ff @(posedge clk125 or negedge npor) begin
        if (!npor) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lasts_q   <= '0;
            full_q    <= 1'b0;
            en_q      <= 1'b0;
            beat_q    <= '0;
            lastcnt_q <= '0;
            idx_q     <= '0;
            bufb_q    <= 16'd1;
            addr_q    <= '0;
            irq_q     <= 1'b0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            lasts_q   <= lasts_d;
            full_q    <= full_d;
            en_q      <= enable;
            beat_q    <= beat_d;
            lastcnt_q <= lastcnt_d;
            idx_q     <= idx_d;
            bufb_q    <= bufb_d;
            addr_q    <= addr_d;
            irq_q     <= irq_d;
            frame_q   <= frame_d;
        end
    end

    assign in_ready       = en_q & ~full_q;
    assign txs_write      = (state_q != ST_IDLE);
    assign txs_writedata  = (state_q == ST_BURST) ? head[127:0] : 128'd0;
    assign txs_address    = addr_q;
    assign txs_burstcount = 6'(BURST_LEN);
    assign irq            = irq_q;
    assign frame_count    = frame_q;

`ifdef TXS_WR_STATS_EN
    logic [31:0] stat_beats_q, stat_stalls_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk125 or negedge npor) begin
        if (!npor) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_beats_q  <= sat_inc(stat_beats_q, accept);
            stat_stalls_q <= sat_inc(stat_stalls_q, txs_write & txs_waitrequest);
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_stalls = stat_stalls_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_txs_burst_writer.sv
// Self-checking bench for txs_burst_writer: random beats and waitrequest against a frame/burst queue model.
module tb_txs_burst_writer;
    localparam int ADDR_W = 22;
    localparam int BL     = 8;
    localparam int FD     = 32;

    logic              clk = 1'b0;
    logic              npor = 1'b0;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       buf_bursts = 16'd16;
    logic              in_valid = 1'b0;
    logic [127:0]      in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              txs_write;
    logic [127:0]      txs_writedata;
    logic [ADDR_W-1:0] txs_address;
    logic [5:0]        txs_burstcount;
    logic              txs_waitrequest = 1'b0;
    logic              irq;
    logic [15:0]       frame_count;
`ifdef TXS_WR_STATS_EN
    logic [31:0]       stat_beats, stat_stalls;
`endif

    always #4 clk = ~clk;

    txs_burst_writer #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk125(clk), .npor(npor), .enable(enable), .base_addr(base_addr),
        .buf_bursts(buf_bursts), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .txs_write(txs_write),
        .txs_writedata(txs_writedata), .txs_address(txs_address),
        .txs_burstcount(txs_burstcount), .txs_waitrequest(txs_waitrequest),
        .irq(irq), .frame_count(frame_count)
`ifdef TXS_WR_STATS_EN
        , .stat_beats(stat_beats), .stat_stalls(stat_stalls)
`endif
    );

    typedef struct {
        logic [127:0]      data;
        logic [ADDR_W-1:0] addr;
        bit                irq;
    } beat_t;

    beat_t             exp_q[$];
    beat_t             mon_e;
    int                n_vec = 0, n_err = 0;
    int                n_exp = 0, exp_frames = 0;
    bit                mon_en = 0, irq_pend = 0, prev_stall = 0;
    logic [127:0]      prev_data;
    logic [ADDR_W-1:0] prev_addr;
    int                acc_cnt = 0, cyc = 0, first_acc = -1, last_acc = -1;
    int                wr_mode = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Ring address of the k-th burst since reset.
    function automatic logic [ADDR_W-1:0] burst_addr(int k);
        int nb = (buf_bursts == 0) ? 1 : int'(buf_bursts);
        return base_addr + ADDR_W'((k % nb) * BL * 16);
    endfunction

    // Each frame occupies whole bursts: its beats, then zeros up to the burst boundary.
    task automatic model_push(input logic [127:0] d, input bit l);
        beat_t b;
        b.data = d; b.addr = burst_addr(n_exp / BL); b.irq = 0;
        exp_q.push_back(b); n_exp++;
        if (l) begin
            while (n_exp % BL != 0) begin
                b.data = '0; b.addr = burst_addr(n_exp / BL);
                exp_q.push_back(b); n_exp++;
            end
            exp_q[exp_q.size()-1].irq = 1;
            exp_frames++;
        end
    endtask

    task automatic send_frame(input int n, input bit with_last, input int gmax);
        for (int i = 0; i < n; i++) begin
            logic [127:0] d = rnd128();
            bit l = with_last && (i == n - 1);
            int t = 0;
            bit hs = 0;
            in_valid = 1'b1; in_data = d; in_last = l;
            while (!hs && t < 2000) begin
                @(negedge clk); hs = in_ready;
                @(posedge clk); #1; t++;
            end
            if (!hs) chk("push_timeout", 0, 1);
            else model_push(d, l);
            in_valid = 1'b0; in_last = 1'b0;
            repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic clear_model();
        exp_q.delete(); n_exp = 0; exp_frames = 0; irq_pend = 0; prev_stall = 0;
        acc_cnt = 0; first_acc = -1; last_acc = -1;
    endtask

    task automatic do_reset();
        mon_en = 0; in_valid = 1'b0; npor = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", txs_write, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_frames", frame_count, 0);
        clear_model();
        npor = 1'b1; mon_en = 1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("frame_count", frame_count, exp_frames);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (wr_mode)
                0:       txs_waitrequest = 1'b0;
                1:       txs_waitrequest = 1'($urandom_range(0, 1));
                default: txs_waitrequest = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("irq", irq, irq_pend);
            irq_pend = 0;
            if (prev_stall) begin
                chk("hold_write", txs_write, 1);
                chk("hold_data", txs_writedata, prev_data);
                chk("hold_addr", txs_address, prev_addr);
            end
            prev_stall = txs_write && txs_waitrequest;
            prev_data  = txs_writedata;
            prev_addr  = txs_address;
            if (txs_write && !txs_waitrequest) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("data", txs_writedata, mon_e.data);
                    chk("addr", txs_address, mon_e.addr);
                    chk("burstcount", txs_burstcount, BL);
                    irq_pend = mon_e.irq;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b1; base_addr = 22'h1000; buf_bursts = 16'd16;

        // Single full frame, no back-pressure: eight back-to-back beats at base.
        wr_mode = 0; do_reset();
        send_frame(8, 1, 0);
        wait_drain();
        chk("t1_back2back", last_acc - first_acc, 7);

        // Two bursts under random waitrequest.
        wr_mode = 1; do_reset();
        send_frame(16, 1, 2);
        wait_drain();

        // Short frame is zero-padded.
        wr_mode = 0; do_reset();
        send_frame(3, 1, 1);
        wait_drain();
        chk("t3_frames", frame_count, 1);

        // Ring wrap with two slots.
        buf_bursts = 16'd2; wr_mode = 0; do_reset();
        send_frame(24, 1, 1);
        wait_drain();
        buf_bursts = 16'd16;

        // Fill the FIFO behind a stalled burst, then release.
        wr_mode = 2; do_reset();
        send_frame(32, 1, 0);
        in_valid = 1'b1; in_data = rnd128(); in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_full_ready", in_ready, 0);
        chk("t5_stalled_write", txs_write, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wr_mode = 0;
        wait_drain();

        // Asynchronous reset in the middle of a burst.
        wr_mode = 2; do_reset();
        send_frame(16, 0, 0);
        wr_mode = 0;
        begin
            int t = 0;
            while (acc_cnt < 3 && t < 200) begin @(posedge clk); #2; t++; end
            chk("t6_reach_beat4", acc_cnt, 3);
        end
        chk("t6_write_before", txs_write, 1);
        mon_en = 0; npor = 1'b0;
        #1;
        chk("t6_async_write", txs_write, 0);
        chk("t6_async_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        npor = 1'b1; mon_en = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_fifo_empty", txs_write, 0);
        chk("t6_frames", frame_count, 0);
        send_frame(8, 1, 1);
        wait_drain();

        // Random frame lengths with random back-pressure, then enable drop.
        wr_mode = 1; do_reset();
        for (int f = 0; f < 6; f++) send_frame($urandom_range(1, 20), 1, 2);
        wait_drain();
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        chk("en_ready_hold", in_ready, 1);
        @(negedge clk);
        chk("en_ready_drop", in_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
